// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard and sequencing controller for a 5-stage RV32I pipeline.
//                Drives the forwarding selects, the load-use stall, the flush
//                on a taken branch, the dmem wait stall with timeout, and the
//                saturating stall/flush performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,      // synchronous, active low
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             use_rs1_d,
  input  logic             use_rs2_d,
  input  logic [4:0]       rs1_x,
  input  logic [4:0]       rs2_x,
  input  logic [4:0]       rd_x,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             regwen_x,
  input  logic             regwen_m,
  input  logic             regwen_w,
  input  logic             load_x,
  input  logic             br_taken_x,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             bubble_x,
  output logic             hold_xm,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // The entry cycle in RUN is the first stall cycle, so the last permitted
  // wait cycle is reached when the counter shows MEM_TIMEOUT-1 elapsed cycles.
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_nxt;
  logic                w_err_set;
  logic                w_load_use;
  logic                r_mem_err;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  // Pick the youngest in-flight producer of a source register; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wen_m, input logic [4:0] dst_m,
                                         input logic       wen_w, input logic [4:0] dst_w);
    if (wen_m && (dst_m != 5'd0) && (dst_m == rs))      return 2'b10;
    else if (wen_w && (dst_w != 5'd0) && (dst_w == rs)) return 2'b01;
    else                                                return 2'b00;
  endfunction

  // Forwarding selects for the two ALU operand muxes, forced to 00 in reset.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (reset) begin
      fwd_a_sel = fwd_sel(rs1_x, regwen_m, rd_m, regwen_w, rd_w);
      fwd_b_sel = fwd_sel(rs2_x, regwen_m, rd_m, regwen_w, rd_w);
    end
  end

  assign w_load_use = load_x && regwen_x && (rd_x != 5'd0) &&
                      ((use_rs1_d && (rs1_d == rd_x)) || (use_rs2_d && (rs2_d == rd_x)));

  // Next-state, wait-counter and pipeline-control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_err_set   = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    bubble_x    = 1'b0;
    hold_xm     = 1'b0;
    if (reset) begin
      case (r_state)
        S_RUN: begin
          if (mem_req_m && !mem_ready) begin
            stall_f     = 1'b1;
            stall_d     = 1'b1;
            hold_xm     = 1'b1;
            w_state_nxt = S_MEM_WAIT;
            w_wait_nxt  = c_WAIT_W'(1);
          end else if (br_taken_x) begin
            flush_d  = 1'b1;
            bubble_x = 1'b1;
          end else if (w_load_use) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_x = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          // Stall holds through the cycle in which mem_ready rises.
          stall_f = 1'b1;
          stall_d = 1'b1;
          hold_xm = 1'b1;
          if (mem_ready) begin
            w_state_nxt = S_RUN;
            w_wait_nxt  = '0;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            // Abandon the access; a pending branch in X is taken up in RUN.
            w_err_set   = 1'b1;
            w_state_nxt = S_RUN;
            w_wait_nxt  = '0;
          end else begin
            w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_RUN;
          w_wait_nxt  = '0;
        end
      endcase
    end
  end

  // State register and wait counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Sticky timeout flag and saturating performance counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_err_set) r_mem_err <= 1'b1;
      if (stall_f && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_d && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl with a
//                reference model feeding an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int CNT_W  = 4;
  localparam int MEM_TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rs1_x = '0, rs2_x = '0;
  logic [4:0] rd_x = '0, rd_m = '0, rd_w = '0;
  logic use_rs1_d = 1'b0, use_rs2_d = 1'b0;
  logic regwen_x = 1'b0, regwen_m = 1'b0, regwen_w = 1'b0;
  logic load_x = 1'b0, br_taken_x = 1'b0, mem_req_m = 1'b0, mem_ready = 1'b0;

  logic             stall_f, stall_d, flush_d, bubble_x, hold_xm, mem_err;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TO)) dut (
    .clock(clock), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rs1_x(rs1_x), .rs2_x(rs2_x), .rd_x(rd_x), .rd_m(rd_m), .rd_w(rd_w),
    .regwen_x(regwen_x), .regwen_m(regwen_m), .regwen_w(regwen_w),
    .load_x(load_x), .br_taken_x(br_taken_x), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .bubble_x(bubble_x),
    .hold_xm(hold_xm), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic sf; logic sd; logic fl; logic bx; logic hx;
    logic [1:0] fa; logic [1:0] fb;
    logic me; logic [CNT_W-1:0] sc; logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_cur;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state.
  logic             m_wait_st = 1'b0;
  int               m_wait    = 0;
  logic [CNT_W-1:0] m_sc      = '0;
  logic [CNT_W-1:0] m_fc      = '0;
  logic             m_err     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (regwen_m && rd_m != 0 && rd_m == rs)      return 2'b10;
    else if (regwen_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic push_expect();
    exp_t e;
    logic lu;
    e = '0;
    lu = load_x && regwen_x && rd_x != 0 &&
         ((use_rs1_d && rs1_d == rd_x) || (use_rs2_d && rs2_d == rd_x));
    if (reset) begin
      e.fa = ref_fwd(rs1_x);
      e.fb = ref_fwd(rs2_x);
      if (m_wait_st) begin
        e.sf = 1; e.sd = 1; e.hx = 1;
      end else if (mem_req_m && !mem_ready) begin
        e.sf = 1; e.sd = 1; e.hx = 1;
      end else if (br_taken_x) begin
        e.fl = 1; e.bx = 1;
      end else if (lu) begin
        e.sf = 1; e.sd = 1; e.bx = 1;
      end
    end
    e.me = m_err; e.sc = m_sc; e.fc = m_fc;
    m_cur = e;
    sb_q.push_back(e);
  endtask

  task automatic model_clock();
    if (!reset) begin
      m_wait_st = 0; m_wait = 0; m_sc = '0; m_fc = '0; m_err = 0;
    end else begin
      if (m_cur.sf && m_sc != '1) m_sc = m_sc + 1'b1;
      if (m_cur.fl && m_fc != '1) m_fc = m_fc + 1'b1;
      if (!m_wait_st) begin
        if (mem_req_m && !mem_ready) begin m_wait_st = 1; m_wait = 1; end
      end else if (mem_ready) begin
        m_wait_st = 0; m_wait = 0;
      end else if (m_wait == MEM_TO - 1) begin
        m_err = 1; m_wait_st = 0; m_wait = 0;
      end else begin
        m_wait = m_wait + 1;
      end
    end
  endtask

  task automatic check_out();
    exp_t e;
    n_cmp++;
    assert (sb_q.size() != 0)
    else begin
      n_err++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    chk("stall_f", 32'(stall_f), 32'(e.sf));
    chk("stall_d", 32'(stall_d), 32'(e.sd));
    chk("flush_d", 32'(flush_d), 32'(e.fl));
    chk("bubble_x", 32'(bubble_x), 32'(e.bx));
    chk("hold_xm", 32'(hold_xm), 32'(e.hx));
    chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e.fa));
    chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e.fb));
    chk("mem_err", 32'(mem_err), 32'(e.me));
    chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
    chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
  endtask

  // One pipeline cycle: predict, sample on the falling edge, advance model.
  task automatic step();
    push_expect();
    @(negedge clock);
    check_out();
    model_clock();
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    // Reset held: every control output low, selects 00, counters 0.
    regwen_m = 1; rd_m = 5'd1; rs1_x = 5'd1;
    step();
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    reset = 1;

    // Forwarding: M beats W on the same register.
    regwen_w = 1; rd_w = 5'd1; rs2_x = 5'd7;
    #1 chk("fwd_a_m_prio", 32'(fwd_a_sel), 32'd2);
    step();
    rd_m = 5'd0;
    #1 chk("fwd_a_w", 32'(fwd_a_sel), 32'd1);
    step();
    rd_w = 5'd0; rs1_x = 5'd0;
    #1 chk("fwd_a_x0", 32'(fwd_a_sel), 32'd0);
    step();
    rd_m = 5'd7; rd_w = 5'd7; rs2_x = 5'd7;
    step();
    regwen_m = 0; regwen_w = 0; rd_m = 0; rd_w = 0; rs2_x = 0;

    // Load-use: lw x5 in X, consumer of x5 in D.
    load_x = 1; regwen_x = 1; rd_x = 5'd5; use_rs1_d = 1; rs1_d = 5'd5;
    step();
    load_x = 0; regwen_x = 0; rd_x = 0; use_rs1_d = 0; rs1_d = 0;
    regwen_w = 1; rd_w = 5'd5; rs1_x = 5'd5;
    step();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    regwen_w = 0; rd_w = 0; rs1_x = 0;
    // Load-use on rs2 with rs1 unused.
    load_x = 1; regwen_x = 1; rd_x = 5'd9; use_rs2_d = 1; rs2_d = 5'd9; rs1_d = 5'd9;
    step();
    load_x = 0; regwen_x = 0; rd_x = 0; use_rs2_d = 0; rs2_d = 0; rs1_d = 0;

    // Taken branch in RUN.
    br_taken_x = 1;
    step();
    br_taken_x = 0;
    step();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);

    // dmem wait: ready low 3 cycles then high, branch pending throughout.
    mem_req_m = 1; br_taken_x = 1;
    repeat (3) step();
    mem_ready = 1;
    step();
    mem_ready = 0; mem_req_m = 0;
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd6);
    chk("mw_flush_defer", 32'(flush_cnt), 32'd1);
    step();
    chk("mw_flush_after", 32'(flush_cnt), 32'd2);
    br_taken_x = 0;

    // Timeout: ready never arrives; stall_cnt saturates at 15.
    mem_req_m = 1;
    repeat (MEM_TO) step();
    mem_req_m = 0;
    chk("to_mem_err", 32'(mem_err), 32'd1);
    chk("to_stall_sat", 32'(stall_cnt), 32'd15);
    repeat (2) step();
    chk("to_err_sticky", 32'(mem_err), 32'd1);
    chk("to_stall_no_wrap", 32'(stall_cnt), 32'd15);

    // Reset asserted mid-wait.
    mem_req_m = 1;
    repeat (2) step();
    reset = 0;
    step();
    reset = 1; mem_req_m = 0;
    step();
    chk("rst_mw_err", 32'(mem_err), 32'd0);
    chk("rst_mw_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_mw_stall_cnt", 32'(stall_cnt), 32'd0);

    n_cmp++;
    assert (sb_q.size() == 0)
    else begin
      n_err++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
